e203_exu_alu_wbck_cmt: RTL and testbench
========================================

// Module: e203_exu_alu_wbck_cmt
// PURPOSE
//  Consumer end of the regular-ALU output channel (alu_o_valid/alu_o_ready). Buffers finished ALU ops
//  in a small FIFO, retires each head entry to the regfile write port, or raises a commit request for
//  ECALL/EBREAK to the exception unit, and parks the core in sleep on WFI until a wake event.
//  Sits between e203_exu_alu_rglr and the regfile/commit logic in the EXU.
// PARAMETERS
//  XLEN     32  data / PC width
//  RFIDX_W  5   regfile index width
//  DEPTH    2   FIFO entries (power of 2, >=2)
// PORTS
//  clk            in   1        core clock
//  rst            in   1        synchronous reset, active-high
//  alu_o_valid    in   1        ALU result valid
//  alu_o_ready    out  1        block accepts result
//  alu_o_wdat     in   XLEN     writeback data
//  alu_o_rdidx    in   RFIDX_W  destination register
//  alu_o_rdwen    in   1        destination write enable
//  alu_o_pc       in   XLEN     instruction PC
//  alu_o_ecall    in   1        instruction is ECALL
//  alu_o_ebreak   in   1        instruction is EBREAK
//  alu_o_wfi      in   1        instruction is WFI
//  rf_wbck_valid  out  1        regfile write request
//  rf_wbck_ready  in   1        regfile accepts write
//  rf_wbck_wdat   out  XLEN     write data
//  rf_wbck_rdidx  out  RFIDX_W  write index
//  cmt_valid      out  1        exception commit request
//  cmt_ready      in   1        exception unit accepts
//  cmt_cause      out  4        3=breakpoint, 11=ECALL
//  cmt_pc         out  XLEN     PC of faulting instruction
//  flush_pulse    out  1        one-cycle pulse after exception commit
//  wfi_wake       in   1        interrupt/debug wake request
//  core_sleep     out  1        high while in WFI sleep
// BEHAVIOUR
//  Reset: FIFO empty, state RUN; all outputs 0 except alu_o_ready=1 after reset deasserts.
//  Accept: push when alu_o_valid & alu_o_ready; alu_o_ready = !full & !flush_cycle. No same-cycle
//   bypass: a pushed entry is visible at head the next cycle (min latency 1 cycle to rf_wbck_valid).
//  Head classification priority: ecall > ebreak > wfi > plain.
//  RUN, plain head: rf_wbck_valid = rdwen; pop when (rf_wbck_ready | !rdwen). Outputs are
//   combinational from head; held stable while rf_wbck_ready=0.
//  RUN, ecall/ebreak head: no regfile write; cmt_valid=1 with cause/pc; on cmt_ready -> pop,
//   go FLUSH. FLUSH (1 cycle): flush_pulse=1, alu_o_ready=0, FIFO cleared (younger entries discarded);
//   -> RUN.
//  RUN, wfi head: pop, no rf/cmt activity, -> SLEEP. If wfi_wake=1 in that same cycle, stay RUN.
//  SLEEP: core_sleep=1, no pops, FIFO still accepts until full; wfi_wake=1 -> RUN next cycle.
//  Empty FIFO: rf_wbck_valid=cmt_valid=0. Full FIFO: alu_o_ready=0 (even if a pop occurs).
//  Pointers are log2(DEPTH)+1 bits; wrap-around via MSB compare for full/empty.
//  rst mid-operation: all state, FIFO contents and pending handshakes discarded next edge.
// STRUCTURE
//  Package e203_alu_wbck_pkg: state enum {RUN, FLUSH, SLEEP}; cause constants CAUSE_BRK=4'd3,
//   CAUSE_ECALL=4'd11; entry struct {wdat, rdidx, rdwen, pc, ecall, ebreak, wfi}.
//  Sub-module e203_alu_wbck_fifo: DEPTH-entry sync FIFO of entry struct with push/pop/full/empty/clr.
// TESTING
//  1 Reset: rst=1 two cycles with alu_o_valid=1 -> all outputs 0; after release alu_o_ready=1, no writes.
//  2 Plain: push wdat=0x1234_5678 rdidx=5 rdwen=1, rf_wbck_ready=1 -> next cycle rf_wbck_valid=1,
//    wdat=0x12345678, rdidx=5; rdwen=0 entry pops with no write.
//  3 Backpressure: rf_wbck_ready=0, push 3 entries -> 2 stored, alu_o_ready=0 on third;
//    release -> writes in order, no loss/duplication.
//  4 ECALL at pc=0x8000_0010 followed by plain entry, cmt_ready low 3 cycles -> cmt_valid held,
//    cause=11; on ready flush_pulse 1 cycle, younger entry never written.
//  5 EBREAK -> cause=3, same flush behaviour.
//  6 WFI then plain entry -> core_sleep=1, plain write held; wfi_wake pulse -> RUN, write next cycle;
//    WFI with wfi_wake already high -> core_sleep never asserts.

Source files
------------

// File: rtl/e203_alu_wbck_pkg.sv
// ---------------------------------------------------------------------------
// e203_alu_wbck_pkg
// Shared types for the ALU writeback/commit stage: datapath widths, the
// sequencing state enum, exception cause codes and the buffered entry format.
// Helper functions classify a head entry so that the top and any future user
// agree on the ecall > ebreak priority.
// ---------------------------------------------------------------------------
package e203_alu_wbck_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned RFIDX_W = 5;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        SLEEP = 2'd2
    } state_e;

    localparam logic [3:0] CAUSE_BRK   = 4'd3;
    localparam logic [3:0] CAUSE_ECALL = 4'd11;

    typedef struct packed {
        logic [XLEN-1:0]    wdat;
        logic [RFIDX_W-1:0] rdidx;
        logic               rdwen;
        logic [XLEN-1:0]    pc;
        logic               ecall;
        logic               ebreak;
        logic               wfi;
    } entry_t;

    // True when the entry must be retired through the exception unit.
    function automatic logic is_exc(input entry_t e);
        return e.ecall | e.ebreak;
    endfunction

    // ECALL wins over EBREAK when both are flagged.
    function automatic logic [3:0] exc_cause(input entry_t e);
        return e.ecall ? CAUSE_ECALL : CAUSE_BRK;
    endfunction

endpackage

// File: rtl/e203_alu_wbck_fifo.sv
// ---------------------------------------------------------------------------
// e203_alu_wbck_fifo
// DEPTH-entry synchronous FIFO of entry_t. Pointers carry one extra wrap bit
// so full/empty are told apart by comparing the MSBs.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   clr_i         drop all entries (wins over push/pop)
//   push_i        write push_data_i when not full
//   pop_i         retire head when not empty
//   head_o        current head entry (valid only when !empty_o)
//   full_o        no free slot
//   empty_o       no stored entry
// ---------------------------------------------------------------------------
module e203_alu_wbck_fifo
    import e203_alu_wbck_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   clr_i,
    input  logic   push_i,
    input  entry_t push_data_i,
    input  logic   pop_i,
    output entry_t head_o,
    output logic   full_o,
    output logic   empty_o
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned PTR_W = AW + 1;

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    entry_t           mem_q [DEPTH];
    logic             do_push_s;
    logic             do_pop_s;

    assign empty_o   = (wptr_q == rptr_q);
    assign full_o    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_push_s = push_i & ~full_o;
    assign do_pop_s  = pop_i & ~empty_o;
    assign head_o    = mem_q[rptr_q[AW-1:0]];

    // Next-state pointer computation; clear empties the FIFO outright.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (clr_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (do_push_s) begin
                wptr_d = wptr_q + PTR_W'(1);
            end else begin
                wptr_d = wptr_q;
            end
            if (do_pop_s) begin
                rptr_d = rptr_q + PTR_W'(1);
            end else begin
                rptr_d = rptr_q;
            end
        end
    end

    // Pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Entry storage; contents are zeroed on reset so stale data never leaks.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push_s && !clr_i) begin
            mem_q[wptr_q[AW-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/e203_exu_alu_wbck_cmt.sv
// ---------------------------------------------------------------------------
// e203_exu_alu_wbck_cmt
// Consumer of the regular-ALU result channel. Finished ops are buffered, then
// the head is either written to the regfile, sent to the exception unit as a
// commit request (ECALL/EBREAK, followed by a one-cycle flush that discards
// younger buffered ops), or parks the core in sleep (WFI) until a wake event.
// XLEN and RFIDX_W come from e203_alu_wbck_pkg since the entry struct is
// built on them.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   alu_o_valid/alu_o_ready       ALU result handshake
//   alu_o_wdat/rdidx/rdwen/pc     result payload
//   alu_o_ecall/ebreak/wfi        instruction class flags
//   rf_wbck_valid/ready           regfile write handshake
//   rf_wbck_wdat/rdidx            regfile write payload
//   cmt_valid/ready               exception commit handshake
//   cmt_cause/cmt_pc              exception cause and faulting PC
//   flush_pulse                   one-cycle pulse after an exception commit
//   wfi_wake                      wake request ending WFI sleep
//   core_sleep                    high while sleeping
// ---------------------------------------------------------------------------
module e203_exu_alu_wbck_cmt
    import e203_alu_wbck_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               alu_o_valid,
    output logic               alu_o_ready,
    input  logic [XLEN-1:0]    alu_o_wdat,
    input  logic [RFIDX_W-1:0] alu_o_rdidx,
    input  logic               alu_o_rdwen,
    input  logic [XLEN-1:0]    alu_o_pc,
    input  logic               alu_o_ecall,
    input  logic               alu_o_ebreak,
    input  logic               alu_o_wfi,
    output logic               rf_wbck_valid,
    input  logic               rf_wbck_ready,
    output logic [XLEN-1:0]    rf_wbck_wdat,
    output logic [RFIDX_W-1:0] rf_wbck_rdidx,
    output logic               cmt_valid,
    input  logic               cmt_ready,
    output logic [3:0]         cmt_cause,
    output logic [XLEN-1:0]    cmt_pc,
    output logic               flush_pulse,
    input  logic               wfi_wake,
    output logic               core_sleep
);

    state_e state_q, state_d;
    entry_t push_data_s;
    entry_t head_s;
    logic   full_s;
    logic   empty_s;
    logic   push_s;
    logic   pop_s;
    logic   clr_s;

    assign push_data_s = '{wdat:   alu_o_wdat,
                           rdidx:  alu_o_rdidx,
                           rdwen:  alu_o_rdwen,
                           pc:     alu_o_pc,
                           ecall:  alu_o_ecall,
                           ebreak: alu_o_ebreak,
                           wfi:    alu_o_wfi};

    // Ready is withheld while full (even if the head pops this cycle) and
    // during the flush cycle so nothing younger than the exception survives.
    assign alu_o_ready = ~rst & ~full_s & (state_q != FLUSH);
    assign push_s      = alu_o_valid & alu_o_ready;
    assign core_sleep  = (state_q == SLEEP);

    e203_alu_wbck_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (clr_s),
        .push_i      (push_s),
        .push_data_i (push_data_s),
        .pop_i       (pop_s),
        .head_o      (head_s),
        .full_o      (full_s),
        .empty_o     (empty_s)
    );

    // Head dispatch and sequencing; payload outputs are zero when not valid.
    always_comb begin
        state_d       = state_q;
        pop_s         = 1'b0;
        clr_s         = 1'b0;
        rf_wbck_valid = 1'b0;
        rf_wbck_wdat  = '0;
        rf_wbck_rdidx = '0;
        cmt_valid     = 1'b0;
        cmt_cause     = 4'd0;
        cmt_pc        = '0;
        flush_pulse   = 1'b0;
        case (state_q)
            RUN: begin
                if (empty_s) begin
                    state_d = RUN;
                end else if (is_exc(head_s)) begin
                    cmt_valid = 1'b1;
                    cmt_cause = exc_cause(head_s);
                    cmt_pc    = head_s.pc;
                    if (cmt_ready) begin
                        pop_s   = 1'b1;
                        state_d = FLUSH;
                    end else begin
                        state_d = RUN;
                    end
                end else if (head_s.wfi) begin
                    // A wake already pending cancels the sleep entirely.
                    pop_s   = 1'b1;
                    state_d = wfi_wake ? RUN : SLEEP;
                end else begin
                    rf_wbck_valid = head_s.rdwen;
                    if (head_s.rdwen) begin
                        rf_wbck_wdat  = head_s.wdat;
                        rf_wbck_rdidx = head_s.rdidx;
                    end else begin
                        rf_wbck_wdat  = '0;
                        rf_wbck_rdidx = '0;
                    end
                    pop_s = rf_wbck_ready | ~head_s.rdwen;
                end
            end
            FLUSH: begin
                flush_pulse = 1'b1;
                clr_s       = 1'b1;
                state_d     = RUN;
            end
            SLEEP: begin
                if (wfi_wake) begin
                    state_d = RUN;
                end else begin
                    state_d = SLEEP;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Sequencing state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_e203_exu_alu_wbck_cmt.sv
module tb_e203_exu_alu_wbck_cmt;

    logic        clk;
    logic        rst;
    logic        alu_o_valid;
    logic        alu_o_ready;
    logic [31:0] alu_o_wdat;
    logic [4:0]  alu_o_rdidx;
    logic        alu_o_rdwen;
    logic [31:0] alu_o_pc;
    logic        alu_o_ecall;
    logic        alu_o_ebreak;
    logic        alu_o_wfi;
    logic        rf_wbck_valid;
    logic        rf_wbck_ready;
    logic [31:0] rf_wbck_wdat;
    logic [4:0]  rf_wbck_rdidx;
    logic        cmt_valid;
    logic        cmt_ready;
    logic [3:0]  cmt_cause;
    logic [31:0] cmt_pc;
    logic        flush_pulse;
    logic        wfi_wake;
    logic        core_sleep;

    int tests;
    int fails;

    e203_exu_alu_wbck_cmt #(.DEPTH(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .alu_o_valid   (alu_o_valid),
        .alu_o_ready   (alu_o_ready),
        .alu_o_wdat    (alu_o_wdat),
        .alu_o_rdidx   (alu_o_rdidx),
        .alu_o_rdwen   (alu_o_rdwen),
        .alu_o_pc      (alu_o_pc),
        .alu_o_ecall   (alu_o_ecall),
        .alu_o_ebreak  (alu_o_ebreak),
        .alu_o_wfi     (alu_o_wfi),
        .rf_wbck_valid (rf_wbck_valid),
        .rf_wbck_ready (rf_wbck_ready),
        .rf_wbck_wdat  (rf_wbck_wdat),
        .rf_wbck_rdidx (rf_wbck_rdidx),
        .cmt_valid     (cmt_valid),
        .cmt_ready     (cmt_ready),
        .cmt_cause     (cmt_cause),
        .cmt_pc        (cmt_pc),
        .flush_pulse   (flush_pulse),
        .wfi_wake      (wfi_wake),
        .core_sleep    (core_sleep)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs change and checks happen here.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [31:0] wdat, input logic [4:0] idx, input logic wen,
                         input logic [31:0] pc, input logic ec, input logic eb, input logic wf);
        alu_o_valid  = 1'b1;
        alu_o_wdat   = wdat;
        alu_o_rdidx  = idx;
        alu_o_rdwen  = wen;
        alu_o_pc     = pc;
        alu_o_ecall  = ec;
        alu_o_ebreak = eb;
        alu_o_wfi    = wf;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rf_wbck_ready = 1'b1;
        cmt_ready = 1'b0;
        wfi_wake = 1'b0;
        drive(32'hCAFE_0001, 5'd1, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        tests++;
        if ({alu_o_ready, rf_wbck_valid, cmt_valid, flush_pulse, core_sleep,
             rf_wbck_wdat, rf_wbck_rdidx, cmt_cause, cmt_pc} !== 78'd0) begin
            fails++;
            $display("FAIL reset_outputs: rdy=%b rfv=%b cmtv=%b fl=%b sl=%b, required all 0",
                     alu_o_ready, rf_wbck_valid, cmt_valid, flush_pulse, core_sleep);
        end
        rst = 1'b0;
        alu_o_valid = 1'b0;
        #1;
        tests++;
        if (alu_o_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready: got %b required 1", alu_o_ready);
        end
        step();
        tests++;
        if (rf_wbck_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_no_write: got %b required 0", rf_wbck_valid);
        end
    endtask

    task automatic test_plain();
        drive(32'h1234_5678, 5'd5, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
        rf_wbck_ready = 1'b1;
        #1;
        tests++;
        if (rf_wbck_valid !== 1'b0) begin
            fails++;
            $display("FAIL plain_no_bypass: got %b required 0", rf_wbck_valid);
        end
        step();
        alu_o_valid = 1'b0;
        #1;
        tests++;
        if ({rf_wbck_valid, rf_wbck_wdat, rf_wbck_rdidx} !== {1'b1, 32'h1234_5678, 5'd5}) begin
            fails++;
            $display("FAIL plain_write: got v=%b d=%h i=%0d required v=1 d=12345678 i=5",
                     rf_wbck_valid, rf_wbck_wdat, rf_wbck_rdidx);
        end
        step();
        tests++;
        if (rf_wbck_valid !== 1'b0) begin
            fails++;
            $display("FAIL plain_popped: got %b required 0", rf_wbck_valid);
        end
        // rdwen=0 entry must pop without a write even with the regfile stalled.
        rf_wbck_ready = 1'b0;
        drive(32'h0000_DEAD, 5'd7, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        alu_o_valid = 1'b0;
        #1;
        tests++;
        if (rf_wbck_valid !== 1'b0) begin
            fails++;
            $display("FAIL nowen_no_write: got %b required 0", rf_wbck_valid);
        end
        step();
        drive(32'h0000_00A5, 5'd3, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        alu_o_valid = 1'b0;
        rf_wbck_ready = 1'b1;
        #1;
        tests++;
        if ({rf_wbck_valid, rf_wbck_wdat, rf_wbck_rdidx} !== {1'b1, 32'h0000_00A5, 5'd3}) begin
            fails++;
            $display("FAIL nowen_popped: got v=%b d=%h i=%0d required v=1 d=000000a5 i=3",
                     rf_wbck_valid, rf_wbck_wdat, rf_wbck_rdidx);
        end
        step();
    endtask

    task automatic test_backpressure();
        rf_wbck_ready = 1'b0;
        drive(32'h0000_0011, 5'd1, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        drive(32'h0000_0022, 5'd2, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        drive(32'h0000_0033, 5'd3, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
        #1;
        tests++;
        if ({alu_o_ready, rf_wbck_valid, rf_wbck_wdat} !== {1'b0, 1'b1, 32'h0000_0011}) begin
            fails++;
            $display("FAIL bp_full: got rdy=%b v=%b d=%h required rdy=0 v=1 d=00000011",
                     alu_o_ready, rf_wbck_valid, rf_wbck_wdat);
        end
        step();
        alu_o_valid = 1'b0;
        #1;
        tests++;
        if ({rf_wbck_wdat, rf_wbck_rdidx} !== {32'h0000_0011, 5'd1}) begin
            fails++;
            $display("FAIL bp_hold: got d=%h i=%0d required d=00000011 i=1", rf_wbck_wdat, rf_wbck_rdidx);
        end
        rf_wbck_ready = 1'b1;
        step();
        tests++;
        if ({rf_wbck_valid, rf_wbck_wdat, rf_wbck_rdidx} !== {1'b1, 32'h0000_0022, 5'd2}) begin
            fails++;
            $display("FAIL bp_second: got v=%b d=%h i=%0d required v=1 d=00000022 i=2",
                     rf_wbck_valid, rf_wbck_wdat, rf_wbck_rdidx);
        end
        step();
        tests++;
        if (rf_wbck_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_no_third: got %b required 0", rf_wbck_valid);
        end
    endtask

    task automatic test_ecall();
        rf_wbck_ready = 1'b1;
        cmt_ready = 1'b0;
        drive(32'h0000_EEEE, 5'd9, 1'b1, 32'h8000_0010, 1'b1, 1'b0, 1'b0);
        step();
        for (int k = 0; k < 3; k++) begin
            if (k == 0) drive(32'h0000_5555, 5'd4, 1'b1, 32'h8000_0014, 1'b0, 1'b0, 1'b0);
            else alu_o_valid = 1'b0;
            #1;
            tests++;
            if ({cmt_valid, cmt_cause, cmt_pc, rf_wbck_valid, flush_pulse} !==
                {1'b1, 4'd11, 32'h8000_0010, 1'b0, 1'b0}) begin
                fails++;
                $display("FAIL ecall_hold[%0d]: got v=%b c=%0d pc=%h rfv=%b fl=%b required v=1 c=11 pc=80000010 rfv=0 fl=0",
                         k, cmt_valid, cmt_cause, cmt_pc, rf_wbck_valid, flush_pulse);
            end
            step();
        end
        cmt_ready = 1'b1;
        step();
        cmt_ready = 1'b0;
        #1;
        tests++;
        if ({flush_pulse, alu_o_ready, cmt_valid, rf_wbck_valid} !== 4'b1000) begin
            fails++;
            $display("FAIL ecall_flush: got fl=%b rdy=%b cmtv=%b rfv=%b required 1 0 0 0",
                     flush_pulse, alu_o_ready, cmt_valid, rf_wbck_valid);
        end
        step();
        tests++;
        if ({flush_pulse, alu_o_ready, rf_wbck_valid, cmt_valid} !== 4'b0100) begin
            fails++;
            $display("FAIL ecall_after: got fl=%b rdy=%b rfv=%b cmtv=%b required 0 1 0 0",
                     flush_pulse, alu_o_ready, rf_wbck_valid, cmt_valid);
        end
    endtask

    task automatic test_ebreak();
        cmt_ready = 1'b0;
        drive(32'h0, 5'd0, 1'b0, 32'h8000_0020, 1'b0, 1'b1, 1'b0);
        step();
        alu_o_valid = 1'b0;
        #1;
        tests++;
        if ({cmt_valid, cmt_cause, cmt_pc} !== {1'b1, 4'd3, 32'h8000_0020}) begin
            fails++;
            $display("FAIL ebreak_cmt: got v=%b c=%0d pc=%h required v=1 c=3 pc=80000020",
                     cmt_valid, cmt_cause, cmt_pc);
        end
        cmt_ready = 1'b1;
        step();
        cmt_ready = 1'b0;
        tests++;
        if (flush_pulse !== 1'b1) begin
            fails++;
            $display("FAIL ebreak_flush: got %b required 1", flush_pulse);
        end
        step();
        tests++;
        if (flush_pulse !== 1'b0) begin
            fails++;
            $display("FAIL ebreak_flush_once: got %b required 0", flush_pulse);
        end
        // ECALL and EBREAK together: ECALL cause wins.
        drive(32'h0, 5'd0, 1'b0, 32'h8000_0030, 1'b1, 1'b1, 1'b1);
        step();
        alu_o_valid = 1'b0;
        #1;
        tests++;
        if ({cmt_valid, cmt_cause} !== {1'b1, 4'd11}) begin
            fails++;
            $display("FAIL prio_cause: got v=%b c=%0d required v=1 c=11", cmt_valid, cmt_cause);
        end
        cmt_ready = 1'b1;
        step();
        cmt_ready = 1'b0;
        step();
    endtask

    task automatic test_wfi();
        rf_wbck_ready = 1'b1;
        wfi_wake = 1'b0;
        drive(32'h0, 5'd0, 1'b0, 32'h8000_0040, 1'b0, 1'b0, 1'b1);
        step();
        drive(32'h0000_7777, 5'd6, 1'b1, 32'h8000_0044, 1'b0, 1'b0, 1'b0);
        #1;
        tests++;
        if ({core_sleep, rf_wbck_valid, cmt_valid} !== 3'b000) begin
            fails++;
            $display("FAIL wfi_head: got sl=%b rfv=%b cmtv=%b required 0 0 0", core_sleep, rf_wbck_valid, cmt_valid);
        end
        step();
        alu_o_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            tests++;
            if ({core_sleep, rf_wbck_valid} !== 2'b10) begin
                fails++;
                $display("FAIL wfi_sleep[%0d]: got sl=%b rfv=%b required 1 0", k, core_sleep, rf_wbck_valid);
            end
            step();
        end
        wfi_wake = 1'b1;
        step();
        wfi_wake = 1'b0;
        #1;
        tests++;
        if ({core_sleep, rf_wbck_valid, rf_wbck_wdat, rf_wbck_rdidx} !== {1'b0, 1'b1, 32'h0000_7777, 5'd6}) begin
            fails++;
            $display("FAIL wfi_wake_write: got sl=%b v=%b d=%h i=%0d required sl=0 v=1 d=00007777 i=6",
                     core_sleep, rf_wbck_valid, rf_wbck_wdat, rf_wbck_rdidx);
        end
        step();
        // WFI with wake already high never sleeps.
        wfi_wake = 1'b1;
        drive(32'h0, 5'd0, 1'b0, 32'h8000_0050, 1'b0, 1'b0, 1'b1);
        step();
        alu_o_valid = 1'b0;
        step();
        wfi_wake = 1'b0;
        #1;
        tests++;
        if (core_sleep !== 1'b0) begin
            fails++;
            $display("FAIL wfi_wake_early: got sl=%b required 0", core_sleep);
        end
        drive(32'h0000_0099, 5'd2, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        alu_o_valid = 1'b0;
        #1;
        tests++;
        if ({core_sleep, rf_wbck_valid, rf_wbck_wdat} !== {1'b0, 1'b1, 32'h0000_0099}) begin
            fails++;
            $display("FAIL wfi_still_run: got sl=%b v=%b d=%h required sl=0 v=1 d=00000099",
                     core_sleep, rf_wbck_valid, rf_wbck_wdat);
        end
        step();
    endtask

    task automatic test_reset_mid();
        rf_wbck_ready = 1'b0;
        drive(32'h0000_ABCD, 5'd8, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        alu_o_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        rf_wbck_ready = 1'b1;
        #1;
        tests++;
        if ({rf_wbck_valid, alu_o_ready} !== 2'b01) begin
            fails++;
            $display("FAIL reset_mid: got rfv=%b rdy=%b required 0 1", rf_wbck_valid, alu_o_ready);
        end
        step();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        alu_o_valid = 1'b0;
        alu_o_wdat = 32'h0;
        alu_o_rdidx = 5'd0;
        alu_o_rdwen = 1'b0;
        alu_o_pc = 32'h0;
        alu_o_ecall = 1'b0;
        alu_o_ebreak = 1'b0;
        alu_o_wfi = 1'b0;
        rf_wbck_ready = 1'b0;
        cmt_ready = 1'b0;
        wfi_wake = 1'b0;
        rst = 1'b1;
        test_reset();
        test_plain();
        test_backpressure();
        test_ecall();
        test_ebreak();
        test_wfi();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
